reversi_turn_sequencer: RTL
===========================

Name: reversi_turn_sequencer

Overview:
- Turn-level controller for the reversi board datapath.
- Accepts a player move or pass, then sequences in order: the move checker, the placement write, and the piece flipper.
- Owns the single board RAM port and muxes it between the checker, the flipper, its own placement write and the display reader.
- Tracks the current player and the move count.

Parameters:
- TIMEOUT_CYCLES, 1023: maximum cycles allowed in CHECK or FLIP before the watchdog aborts.
- TW, 10: watchdog counter width; must satisfy 2^TW > TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous, active-low reset
- move_req  in  1  one-cycle pulse; latch move_x/move_y and start a turn
- move_x  in  3  column 0..7
- move_y  in  3  row 0..7
- pass_req  in  1  one-cycle pulse; current player passes
- player  out  1  side to move (0 = black, 1 = white)
- cur_x  out  3  latched move column (to checker/flipper)
- cur_y  out  3  latched move row (to checker/flipper)
- chk_en  out  1  held high for the whole CHECK state
- chk_addr  in  6  checker RAM read address
- chk_done  in  1  checker finished
- chk_valid  in  1  move legal; sampled with chk_done
- chk_dirs  in  8  legal-direction mask; sampled with chk_done
- flip_en  out  1  held high for the whole FLIP state
- flip_dirs  out  8  latched chk_dirs
- flip_addr  in  6  flipper RAM address
- flip_wren  in  1  flipper write enable
- flip_data  in  2  flipper write data
- flip_done  in  1  flipper finished
- disp_addr  in  6  display read address (used in IDLE only)
- ram_addr  out  6  board RAM address; cell index = y*8 + x
- ram_wren  out  1  board RAM write enable
- ram_data  out  2  board RAM write data, {occupied, colour}
- busy  out  1  state != IDLE
- turn_done  out  1  pulse after a successful move or a pass
- move_rejected  out  1  pulse on an illegal or occupied move
- err  out  1  sticky; watchdog fired
- move_count  out  7  completed moves; passes excluded

Behaviour:
- Reset: IDLE; player=0; cur_x=cur_y=0; flip_dirs=0; move_count=0; err=0. All pulse outputs, chk_en, flip_en and ram_wren are 0. Reset wins mid-turn and aborts it without any RAM write.
- RAM mux (combinational, by state):
  - IDLE: ram_addr=disp_addr, ram_wren=0.
  - CHECK: ram_addr=chk_addr, ram_wren=0.
  - PLACE: ram_addr={cur_y,cur_x}, ram_wren=1, ram_data={1,player}.
  - FLIP: addr/wren/data come from the flipper.
  - All other states: ram_wren=0.
- IDLE:
  - move_req: latch x/y, go to CHECK.
  - pass_req alone: go to PASS.
  - Both together: move_req wins and pass_req is ignored.
  - Requests arriving while busy are ignored, not queued.
- CHECK: chk_en=1 and the watchdog counts.
  - chk_done with chk_valid=1 and chk_dirs!=0: latch flip_dirs, go to PLACE.
  - chk_done otherwise: go to REJECT.
  - Watchdog reaches TIMEOUT_CYCLES: set err, go to REJECT.
- PLACE: one cycle, then FLIP.
- FLIP: flip_en=1 and the watchdog counts.
  - flip_done: go to SWITCH.
  - Timeout: set err, go to SWITCH; the board may be partially flipped.
- SWITCH: one cycle; toggle player, move_count += 1 (saturates at 127), pulse turn_done; next IDLE.
- PASS: one cycle; toggle player, pulse turn_done, move_count unchanged; next IDLE.
- REJECT: one cycle; pulse move_rejected, player unchanged; next IDLE.
- Watchdog: cleared on entry to CHECK and to FLIP.
- Latency, legal move (move_req at cycle 0):
  - chk_en high from cycle 1.
  - chk_done at cycle N gives PLACE at N+1 and FLIP at N+2.
  - flip_done at M gives turn_done at M+1, with player toggled at M+2.

Optional Feature:
- Macro: REVERSI_PASS_GAMEOVER_EN.
- Defined:
  - Adds output game_over (1 bit, reset 0) and a 1-bit consecutive-pass flag.
  - The flag is set by PASS and cleared by SWITCH.
  - A PASS while the flag is already set asserts game_over, which is sticky until reset.
  - move_count==60 also asserts game_over.
  - While game_over=1, move_req and pass_req are ignored.
- Undefined: no game_over port; passes only toggle player.

Test Plan:
- Legal move: reset, move_req x=2 y=3; chk_done with valid=1, dirs=8'h01; flip_done 5 cycles later -> PLACE writes addr 26, data 2'b10; flip_dirs=8'h01; turn_done pulse; player=1; move_count=1.
- Illegal move: chk_done with valid=0 -> move_rejected pulse, no ram_wren, player unchanged, move_count=0.
- Valid with empty mask: chk_valid=1, chk_dirs=0 -> REJECT; no write.
- Watchdog: chk_done never asserted -> after 1023 CHECK cycles err=1 and move_rejected pulse; next move_req is still accepted.
- Arbitration/concurrency: move_req and pass_req in the same cycle -> move path taken. Second move_req while busy -> ignored. In IDLE, ram_addr follows disp_addr=6'd63.
- Feature on: pass, pass -> game_over=1; subsequent move_req ignored, busy stays 0.

Source files
------------

// File: rtl/reversi_turn_sequencer_if.sv
// Checker / flipper / board-RAM bundle between the turn sequencer (master)
// and the reversi board datapath (slave).
interface reversi_turn_sequencer_if;
  logic [2:0] cur_x;
  logic [2:0] cur_y;
  logic       chk_en;
  logic [5:0] chk_addr;
  logic       chk_done;
  logic       chk_valid;
  logic [7:0] chk_dirs;
  logic       flip_en;
  logic [7:0] flip_dirs;
  logic [5:0] flip_addr;
  logic       flip_wren;
  logic [1:0] flip_data;
  logic       flip_done;
  logic [5:0] ram_addr;
  logic       ram_wren;
  logic [1:0] ram_data;

  // Strobes are level-qualified: chk_en/flip_en are held for the whole
  // CHECK/FLIP state, chk_done/flip_done are single-cycle and only honoured
  // while the matching enable is high; chk_valid/chk_dirs are sampled with chk_done.
  modport master (
    output cur_x, cur_y, chk_en, flip_en, flip_dirs, ram_addr, ram_wren, ram_data,
    input  chk_addr, chk_done, chk_valid, chk_dirs,
    input  flip_addr, flip_wren, flip_data, flip_done
  );

  modport slave (
    input  cur_x, cur_y, chk_en, flip_en, flip_dirs, ram_addr, ram_wren, ram_data,
    output chk_addr, chk_done, chk_valid, chk_dirs,
    output flip_addr, flip_wren, flip_data, flip_done
  );
endinterface

// File: rtl/reversi_turn_sequencer.sv
// Reversi turn controller: move/pass intake, check -> place -> flip sequencing,
// board RAM port mux. Optional game-over tracking via REVERSI_PASS_GAMEOVER_EN.
module reversi_turn_sequencer #(
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int TW             = 10
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       move_req,
  input  logic [2:0] move_x,
  input  logic [2:0] move_y,
  input  logic       pass_req,
  input  logic [5:0] disp_addr,
  reversi_turn_sequencer_if.master bus,
  output logic       player,
  output logic       busy,
  output logic       turn_done,
  output logic       move_rejected,
  output logic       err,
  output logic [6:0] move_count,
`ifdef REVERSI_PASS_GAMEOVER_EN
  output logic       game_over,
`endif
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_PLACE  = 3'd2,
    S_FLIP   = 3'd3,
    S_SWITCH = 3'd4,
    S_PASS   = 3'd5,
    S_REJECT = 3'd6
  } state_t;

  // Last watchdog value before abort: CHECK/FLIP last at most TIMEOUT_CYCLES cycles.
  localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t        state_q, state_d;
  logic          player_q, player_d;
  logic [2:0]    cur_x_q, cur_x_d;
  logic [2:0]    cur_y_q, cur_y_d;
  logic [7:0]    flip_dirs_q, flip_dirs_d;
  logic [6:0]    move_count_q, move_count_d;
  logic          err_q, err_d;
  logic [TW-1:0] wdog_q, wdog_d;
  logic          req_ok;

`ifdef REVERSI_PASS_GAMEOVER_EN
  logic pass_flag_q, pass_flag_d;
  logic game_over_q, game_over_d;
  assign req_ok    = !game_over_q;
  assign game_over = game_over_q;
`else
  assign req_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      player_q     <= 1'b0;
      cur_x_q      <= '0;
      cur_y_q      <= '0;
      flip_dirs_q  <= '0;
      move_count_q <= '0;
      err_q        <= 1'b0;
      wdog_q       <= '0;
`ifdef REVERSI_PASS_GAMEOVER_EN
      pass_flag_q  <= 1'b0;
      game_over_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      player_q     <= player_d;
      cur_x_q      <= cur_x_d;
      cur_y_q      <= cur_y_d;
      flip_dirs_q  <= flip_dirs_d;
      move_count_q <= move_count_d;
      err_q        <= err_d;
      wdog_q       <= wdog_d;
`ifdef REVERSI_PASS_GAMEOVER_EN
      pass_flag_q  <= pass_flag_d;
      game_over_q  <= game_over_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    player_d     = player_q;
    cur_x_d      = cur_x_q;
    cur_y_d      = cur_y_q;
    flip_dirs_d  = flip_dirs_q;
    move_count_d = move_count_q;
    err_d        = err_q;
    wdog_d       = wdog_q;
`ifdef REVERSI_PASS_GAMEOVER_EN
    pass_flag_d  = pass_flag_q;
    game_over_d  = game_over_q || (move_count_q == 7'd60);
`endif
    case (state_q)
      S_IDLE: begin
        // move_req outranks a simultaneous pass_req
        if (req_ok && move_req) begin
          cur_x_d = move_x;
          cur_y_d = move_y;
          wdog_d  = '0;
          state_d = S_CHECK;
        end else if (req_ok && pass_req) begin
          state_d = S_PASS;
        end
      end
      S_CHECK: begin
        wdog_d = wdog_q + 1'b1;
        if (bus.chk_done) begin
          if (bus.chk_valid && (bus.chk_dirs != 8'h00)) begin
            flip_dirs_d = bus.chk_dirs;
            state_d     = S_PLACE;
          end else begin
            state_d = S_REJECT;
          end
        end else if (wdog_q == WD_LAST) begin
          err_d   = 1'b1;
          state_d = S_REJECT;
        end
      end
      S_PLACE: begin
        wdog_d  = '0;
        state_d = S_FLIP;
      end
      S_FLIP: begin
        wdog_d = wdog_q + 1'b1;
        if (bus.flip_done) begin
          state_d = S_SWITCH;
        end else if (wdog_q == WD_LAST) begin
          err_d   = 1'b1;
          state_d = S_SWITCH;
        end
      end
      S_SWITCH: begin
        player_d = !player_q;
        if (move_count_q != 7'd127) move_count_d = move_count_q + 1'b1;
`ifdef REVERSI_PASS_GAMEOVER_EN
        pass_flag_d = 1'b0;
`endif
        state_d = S_IDLE;
      end
      S_PASS: begin
        player_d = !player_q;
`ifdef REVERSI_PASS_GAMEOVER_EN
        if (pass_flag_q) game_over_d = 1'b1;
        pass_flag_d = 1'b1;
`endif
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Board RAM port ownership follows the state.
  always_comb begin
    bus.ram_addr = 6'd0;
    bus.ram_wren = 1'b0;
    bus.ram_data = 2'b00;
    case (state_q)
      S_IDLE:  bus.ram_addr = disp_addr;
      S_CHECK: bus.ram_addr = bus.chk_addr;
      S_PLACE: begin
        bus.ram_addr = {cur_y_q, cur_x_q};
        bus.ram_wren = 1'b1;
        bus.ram_data = {1'b1, player_q};
      end
      S_FLIP: begin
        bus.ram_addr = bus.flip_addr;
        bus.ram_wren = bus.flip_wren;
        bus.ram_data = bus.flip_data;
      end
      default: ;
    endcase
  end

  assign bus.cur_x     = cur_x_q;
  assign bus.cur_y     = cur_y_q;
  assign bus.chk_en    = (state_q == S_CHECK);
  assign bus.flip_en   = (state_q == S_FLIP);
  assign bus.flip_dirs = flip_dirs_q;

  assign player        = player_q;
  assign busy          = (state_q != S_IDLE);
  assign turn_done     = (state_q == S_SWITCH) || (state_q == S_PASS);
  assign move_rejected = (state_q == S_REJECT);
  assign err           = err_q;
  assign move_count    = move_count_q;
  assign state_dbg     = state_q;

endmodule
